// File: rtl/pll_lock_monitor.sv
// Purpose: filters the async PLL lock flag into a clean registered system reset and counts loss-of-lock events.
// Latency: 2-flop sync + STABLE_CYCLES qualification before release; loss of lock drops sys_rst_n 3 edges after locked_i falls.
// Backpressure: none; free-running monitor, lost_clr is a single-cycle synchronous clear.
// Build option: define PLL_MON_RETRY_EN to add the lock timeout and PLL_RESET retry pulse.
module pll_lock_monitor #(
    parameter int STABLE_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES   = 65536,
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOST_W           = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              locked_i,
    input  logic              lost_clr,
    output logic              sys_rst_n,
    output logic              ready,
    output logic              pll_rst,
    output logic [LOST_W-1:0] lost_count
);

    localparam int MAX_A   = (STABLE_CYCLES > TIMEOUT_CYCLES) ? STABLE_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_A > RST_PULSE_CYCLES) ? MAX_A : RST_PULSE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    // The WAIT_LOCK cycle that first sees locked_s high is the first qualifying
    // cycle, so STABLE only has to count the remaining STABLE_CYCLES-1 of them.
    localparam logic [CNT_W-1:0] STABLE_LAST =
        (STABLE_CYCLES > 1) ? CNT_W'(STABLE_CYCLES - 2) : '0;
`ifdef PLL_MON_RETRY_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STABLE    = 2'd1,
        S_RUN       = 2'd2
`ifdef PLL_MON_RETRY_EN
        , S_PLL_RESET = 2'd3
`endif
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [1:0]       sync_q;
    logic             locked_s;
    logic             loss_evt;

    assign locked_s = sync_q[1];

    // Two-flop synchronizer: the only place locked_i is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], locked_i};
        end
    end

    // Next-state and shared counter logic.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        loss_evt = 1'b0;
        case (state_q)
            S_WAIT_LOCK: begin
                cnt_n = cnt_q + CNT_W'(1);
                if (locked_s) begin
                    cnt_n   = '0;
                    state_n = (STABLE_CYCLES > 1) ? S_STABLE : S_RUN;
                end
`ifdef PLL_MON_RETRY_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_n   = '0;
                    state_n = S_PLL_RESET;
                end
`endif
            end
            S_STABLE: begin
                cnt_n = cnt_q + CNT_W'(1);
                if (!locked_s) begin
                    // Any dropout restarts qualification from scratch.
                    cnt_n   = '0;
                    state_n = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    cnt_n    = '0;
                    state_n  = S_WAIT_LOCK;
                    loss_evt = 1'b1;
                end
            end
`ifdef PLL_MON_RETRY_EN
            S_PLL_RESET: begin
                // Lock flag is meaningless while the PLL is held in reset.
                cnt_n = cnt_q + CNT_W'(1);
                if (cnt_q == PULSE_LAST) begin
                    cnt_n   = '0;
                    state_n = S_WAIT_LOCK;
                end
            end
`endif
            default: begin
                cnt_n   = '0;
                state_n = S_WAIT_LOCK;
            end
        endcase
    end

    // State, counter and outputs decoded from next state so they move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_WAIT_LOCK;
            cnt_q     <= '0;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
`ifdef PLL_MON_RETRY_EN
            pll_rst   <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            sys_rst_n <= (state_n == S_RUN);
            ready     <= (state_n == S_RUN);
`ifdef PLL_MON_RETRY_EN
            pll_rst   <= (state_n == S_PLL_RESET);
`endif
        end
    end

`ifndef PLL_MON_RETRY_EN
    assign pll_rst = 1'b0;
`endif

    // Saturating loss counter; a clear coinciding with a loss keeps that loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_count <= '0;
        end else if (lost_clr) begin
            lost_count <= loss_evt ? LOST_W'(1) : '0;
        end else if (loss_evt && (lost_count != {LOST_W{1'b1}})) begin
            lost_count <= lost_count + LOST_W'(1);
        end
    end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Purpose: directed self-checking bench for pll_lock_monitor (STABLE=8, TIMEOUT=32, PULSE=4, LOST_W=2).
// Latency: expected edges are hand-derived from the locked_i change, edge 1 being the first clk rise after it.
// Backpressure: n/a; stimulus driven 1ns after clk rise, outputs sampled at the same point.
module tb_pll_lock_monitor;

    localparam int STABLE_CYCLES    = 8;
    localparam int TIMEOUT_CYCLES   = 32;
    localparam int RST_PULSE_CYCLES = 4;
    localparam int LOST_W           = 2;

    logic              clk;
    logic              rst_n;
    logic              locked_i;
    logic              lost_clr;
    logic              sys_rst_n;
    logic              ready;
    logic              pll_rst;
    logic [LOST_W-1:0] lost_count;

    int n_checks;
    int n_fail;

    pll_lock_monitor #(
        .STABLE_CYCLES    (STABLE_CYCLES),
        .TIMEOUT_CYCLES   (TIMEOUT_CYCLES),
        .RST_PULSE_CYCLES (RST_PULSE_CYCLES),
        .LOST_W           (LOST_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .locked_i   (locked_i),
        .lost_clr   (lost_clr),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .pll_rst    (pll_rst),
        .lost_count (lost_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clk edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, release 1ns after an edge; next rise is edge 1.
    task automatic do_reset();
        rst_n    = 1'b0;
        locked_i = 1'b0;
        lost_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Raise lock and wait the full qualification time (reaches RUN).
    task automatic go_run();
        locked_i = 1'b1;
        repeat (STABLE_CYCLES + 2) step();
    endtask

    // Drop lock and wait until the loss has propagated.
    task automatic drop_lock();
        locked_i = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        locked_i = 1'b1;
        lost_clr = 1'b0;
        #2;
        n_checks++;
        if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_sys_rst_n: got %b expected 0", sys_rst_n); end
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_checks++;
        if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL reset_pll_rst: got %b expected 0", pll_rst); end
        n_checks++;
        if (lost_count !== 2'd0) begin n_fail++; $display("FAIL reset_lost_count: got %0d expected 0", lost_count); end
    endtask

    task automatic test_lock_release();
        logic exp;
        do_reset();
        locked_i = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            exp = (e >= 10);
            n_checks++;
            if (sys_rst_n !== exp) begin n_fail++; $display("FAIL release_sys_rst_n edge %0d: got %b expected %b", e, sys_rst_n, exp); end
            n_checks++;
            if (ready !== exp) begin n_fail++; $display("FAIL release_ready edge %0d: got %b expected %b", e, ready, exp); end
        end
        n_checks++;
        if (lost_count !== 2'd0) begin n_fail++; $display("FAIL release_lost_count: got %0d expected 0", lost_count); end
    endtask

    task automatic test_glitch();
        logic exp;
        do_reset();
        locked_i = 1'b1;
        repeat (6) step();
        // Low for one cycle so the FSM sees it while cnt is 5 in STABLE.
        locked_i = 1'b0;
        step();
        locked_i = 1'b1;
        // Lock returned before edge 8, so RUN is due at edge 17.
        for (int e = 8; e <= 19; e++) begin
            step();
            exp = (e >= 17);
            n_checks++;
            if (ready !== exp) begin n_fail++; $display("FAIL glitch_ready edge %0d: got %b expected %b", e, ready, exp); end
        end
        n_checks++;
        if (lost_count !== 2'd0) begin n_fail++; $display("FAIL glitch_lost_count: got %0d expected 0", lost_count); end
    endtask

    task automatic test_unlock();
        do_reset();
        go_run();
        locked_i = 1'b0;
        step();
        step();
        n_checks++;
        if (sys_rst_n !== 1'b1) begin n_fail++; $display("FAIL unlock_edge2_sys_rst_n: got %b expected 1", sys_rst_n); end
        step();
        n_checks++;
        if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL unlock_edge3_sys_rst_n: got %b expected 0", sys_rst_n); end
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL unlock_edge3_ready: got %b expected 0", ready); end
        n_checks++;
        if (lost_count !== 2'd1) begin n_fail++; $display("FAIL unlock_lost_count: got %0d expected 1", lost_count); end
    endtask

    task automatic test_saturate_clear();
        logic [1:0] exp_l;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            go_run();
            n_checks++;
            if (ready !== 1'b1) begin n_fail++; $display("FAIL sat_run %0d ready: got %b expected 1", i, ready); end
            drop_lock();
            exp_l = (i < 3) ? 2'(i) : 2'd3;
            n_checks++;
            if (lost_count !== exp_l) begin n_fail++; $display("FAIL sat_count event %0d: got %0d expected %0d", i, lost_count, exp_l); end
        end
        // Sixth loss arrives on the same edge as the clear.
        go_run();
        locked_i = 1'b0;
        step();
        step();
        lost_clr = 1'b1;
        step();
        lost_clr = 1'b0;
        n_checks++;
        if (lost_count !== 2'd1) begin n_fail++; $display("FAIL clr_with_event: got %0d expected 1", lost_count); end
        // Clear with no event.
        lost_clr = 1'b1;
        step();
        lost_clr = 1'b0;
        n_checks++;
        if (lost_count !== 2'd0) begin n_fail++; $display("FAIL clr_alone: got %0d expected 0", lost_count); end
    endtask

    task automatic test_timeout();
        logic exp;
        do_reset();
        locked_i = 1'b0;
`ifdef PLL_MON_RETRY_EN
        for (int e = 1; e <= 80; e++) begin
            step();
            exp = ((e >= 32) && (e <= 35)) || ((e >= 68) && (e <= 71));
            n_checks++;
            if (pll_rst !== exp) begin n_fail++; $display("FAIL timeout_pll_rst edge %0d: got %b expected %b", e, pll_rst, exp); end
        end
`else
        exp = 1'b0;
        for (int e = 1; e <= 200; e++) begin
            step();
            n_checks++;
            if (pll_rst !== exp) begin n_fail++; $display("FAIL no_retry_pll_rst edge %0d: got %b expected 0", e, pll_rst); end
        end
`endif
        n_checks++;
        if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL timeout_sys_rst_n: got %b expected 0", sys_rst_n); end
    endtask

    task automatic test_async_reset();
        do_reset();
        go_run();
        drop_lock();
        go_run();
        n_checks++;
        if ((ready !== 1'b1) || (lost_count !== 2'd1)) begin
            n_fail++; $display("FAIL arst_pre: got ready=%b lost=%0d expected ready=1 lost=1", ready, lost_count);
        end
        // Assert reset mid-cycle and look before the next clk rise.
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL arst_sys_rst_n: got %b expected 0", sys_rst_n); end
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready: got %b expected 0", ready); end
        n_checks++;
        if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL arst_pll_rst: got %b expected 0", pll_rst); end
        n_checks++;
        if (lost_count !== 2'd0) begin n_fail++; $display("FAIL arst_lost_count: got %0d expected 0", lost_count); end
`ifdef PLL_MON_RETRY_EN
        do_reset();
        locked_i = 1'b0;
        repeat (33) step();
        n_checks++;
        if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL arst_pulse_pre: got %b expected 1", pll_rst); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL arst_mid_pulse_pll_rst: got %b expected 0", pll_rst); end
`endif
        do_reset();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        locked_i = 1'b0;
        lost_clr = 1'b0;
        test_reset();
        test_lock_release();
        test_glitch();
        test_unlock();
        test_saturate_clear();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
